// File: rtl/composite_memory_pkg.sv
// composite_memory_pkg: shared sizing constants and address-field types for the banked RAM
package composite_memory_pkg;
    localparam int ADDR_WIDTH   = 16;
    localparam int DATA_WIDTH   = 8;
    localparam int BANK_BITS    = 2;
    localparam int NUM_BANKS    = 2 ** BANK_BITS;
    localparam int OFFSET_WIDTH = ADDR_WIDTH - BANK_BITS;
    localparam int BANK_DEPTH   = 2 ** OFFSET_WIDTH;
    typedef logic [BANK_BITS-1:0]    bank_idx_t;
    typedef logic [OFFSET_WIDTH-1:0] offset_t;
endpackage

// File: rtl/memory_bank.sv
// memory_bank: single-port synchronous RAM with registered read
module memory_bank #(
    parameter int AW = 14,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);
    logic [DW-1:0] mem [2**AW];
    // enabled write stores din; enabled read loads the output register, which otherwise holds
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) mem[addr] <= din;
            else dout <= mem[addr];
        end
    end
endmodule

// File: rtl/composite_memory.sv
// composite_memory: 64 KiB byte RAM built from four 16 KiB banks selected by the top address bits
module composite_memory
    import composite_memory_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);
    bank_idx_t             bank, bank_q;
    offset_t               offset;
    logic [NUM_BANKS-1:0]  sel;
    logic                  valid_q;
    logic [DATA_WIDTH-1:0] bank_dout [NUM_BANKS];
    assign bank   = addr[ADDR_WIDTH-1 -: BANK_BITS];
    assign offset = addr[OFFSET_WIDTH-1:0];
    // one-hot bank enable; reset blocks every access so a write during reset is dropped
    always_comb begin
        sel = '0;
        if (!rst) sel[bank] = 1'b1;
    end
    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        memory_bank #(.AW(OFFSET_WIDTH), .DW(DATA_WIDTH)) u_bank (
            .clk  (clk),
            .en   (sel[g]),
            .we   (we),
            .addr (offset),
            .din  (din),
            .dout (bank_dout[g])
        );
    end
    // bank-select and valid flag follow reads only, so dout holds across writes and
    // reads as zero after reset instead of exposing unreset bank output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            bank_q  <= '0;
            valid_q <= 1'b0;
        end else if (!we) begin
            bank_q  <= bank;
            valid_q <= 1'b1;
        end
    end
    assign dout = valid_q ? bank_dout[bank_q] : '0;
endmodule

// File: tb/tb_composite_memory.sv
// tb_composite_memory: randomized scoreboard bench against a byte-array model of the RAM
module tb_composite_memory;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we = 1'b0;
    logic [15:0] addr = '0;
    logic [7:0]  din = '0;
    logic [7:0]  dout;
    int          checks = 0;
    int          failures = 0;
    logic [7:0]  model [int];
    int          written [$];
    logic [7:0]  exp_q [$];
    composite_memory dut (
        .clk  (clk),
        .rst  (rst),
        .we   (we),
        .addr (addr),
        .din  (din),
        .dout (dout)
    );
    always #5 clk = ~clk;
    task automatic op(input logic r, input logic w, input logic [15:0] a, input logic [7:0] d);
        rst  = r;
        we   = w;
        addr = a;
        din  = d;
        if (!r && w) begin
            if (!model.exists(int'(a))) written.push_back(int'(a));
            model[int'(a)] = d;
        end
        if (!r && !w) exp_q.push_back(model[int'(a)]);
        @(posedge clk);
        #1;
    endtask
    // monitor: classify each edge, then compare dout on the following falling edge
    initial begin
        logic       r, w;
        logic [7:0] last_exp, e;
        last_exp = 8'h00;
        forever begin
            @(posedge clk);
            r = rst;
            w = we;
            @(negedge clk);
            checks++;
            if (r) begin
                last_exp = 8'h00;
                if (dout !== 8'h00) begin
                    failures++;
                    $display("FAIL reset: dout=%h expected=00", dout);
                end
            end else if (w) begin
                if (dout !== last_exp) begin
                    failures++;
                    $display("FAIL hold: dout=%h expected=%h", dout, last_exp);
                end
            end else if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL read: dout=%h but no expected value queued", dout);
            end else begin
                e = exp_q.pop_front();
                last_exp = e;
                if (dout !== e) begin
                    failures++;
                    $display("FAIL read: dout=%h expected=%h", dout, e);
                end
            end
        end
    end
    initial begin
        logic [15:0] a;
        op(1, 0, 16'h0000, 8'h00);
        op(1, 0, 16'h0000, 8'h00);
        op(0, 1, 16'h0000, 8'hA5);
        op(0, 1, 16'h4001, 8'h5A);
        op(0, 1, 16'h8002, 8'h3C);
        op(0, 1, 16'hC003, 8'h7E);
        op(0, 0, 16'h0000, 8'h00);
        op(0, 0, 16'h4001, 8'h00);
        op(0, 0, 16'h8002, 8'h00);
        op(0, 0, 16'hC003, 8'h00);
        op(0, 1, 16'h0010, 8'h11);
        op(0, 1, 16'h4010, 8'h22);
        op(0, 1, 16'h8010, 8'h33);
        op(0, 1, 16'hC010, 8'h44);
        op(0, 0, 16'h0010, 8'h00);
        op(0, 0, 16'h4010, 8'h00);
        op(0, 0, 16'h8010, 8'h00);
        op(0, 0, 16'hC010, 8'h00);
        op(0, 1, 16'h3FFF, 8'hF0);
        op(0, 1, 16'h4000, 8'h0F);
        op(0, 1, 16'hFFFF, 8'hAA);
        op(0, 1, 16'h0000, 8'h55);
        op(0, 0, 16'h3FFF, 8'h00);
        op(0, 0, 16'h4000, 8'h00);
        op(0, 0, 16'hFFFF, 8'h00);
        op(0, 0, 16'h0000, 8'h00);
        op(0, 1, 16'h1234, 8'hC3);
        op(0, 0, 16'h1234, 8'h00);
        op(0, 1, 16'h2000, 8'h66);
        op(1, 1, 16'h2000, 8'h99);
        op(0, 0, 16'h2000, 8'h00);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                a = 16'($urandom);
                op(1, 1'($urandom), a, 8'($urandom));
            end else if ($urandom_range(0, 1) == 0) begin
                a = ($urandom_range(0, 3) == 0) ? 16'(written[$urandom_range(0, written.size() - 1)]) : 16'($urandom);
                op(0, 1, a, 8'($urandom));
            end else begin
                a = 16'(written[$urandom_range(0, written.size() - 1)]);
                op(0, 0, a, 8'h00);
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expected reads left, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/composite_memory.md
Name: composite_memory

Overview:
- 64 KiB byte-addressable synchronous RAM built from four identical 16 KiB banks.
- addr[15:14] selects the bank; addr[13:0] is the word offset inside that bank.
- Single-port: one write or one read per cycle, with registered read data.
- Used as the general-purpose data memory; the banking lets a future revision add per-bank enables or power gating.

Parameters:
- ADDR_WIDTH, 16, total byte address width.
- DATA_WIDTH, 8, width of a memory word.
- BANK_BITS, 2, number of upper address bits used as bank select (NUM_BANKS = 2**BANK_BITS = 4).
- Derived constant OFFSET_WIDTH = ADDR_WIDTH - BANK_BITS = 14, so BANK_DEPTH = 16384.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- we  input  1  write enable; 1 = write din at addr, 0 = read addr.
- addr  input  ADDR_WIDTH  byte address; [15:14] bank, [13:0] offset.
- din  input  DATA_WIDTH  write data.
- dout  output  DATA_WIDTH  registered read data.

Behaviour:
- Bank decode:
  - bank = addr[ADDR_WIDTH-1 -: BANK_BITS]; offset = addr[OFFSET_WIDTH-1:0].
  - Exactly one bank is enabled per access.
  - Unselected banks hold their contents and must not write.
- Write:
  - At a rising clk edge with rst=0 and we=1, bank[bank][offset] <= din.
  - Data is readable from the following cycle onward.
- Read:
  - At a rising clk edge with rst=0 and we=0, dout <= bank[bank][offset].
  - Latency is one cycle: addr applied before edge N gives valid dout after edge N, held until the next update.
  - The bank-select used by the output mux is registered alongside the bank read, so dout always matches the address of the previous cycle.
- Write cycle output: while we=1, dout holds its previous value; no write-through or read-during-write data is presented.
- Reset:
  - At a rising edge with rst=1, dout <= 0 and the registered bank-select <= 0.
  - Writes are suppressed during any cycle with rst=1, including a reset asserted in the middle of a write sequence.
  - Memory array contents are not cleared; they are retained across reset. Contents after power-up are undefined and are never read by a correct user before writing.
- Address boundaries:
  - Offsets wrap within a bank only through the address the user supplies; there is no internal address increment.
  - 0x3FFF and 0x4000 lie in different banks and must not alias.
  - Writing the same offset in two banks stores two independent values.
- Back-to-back accesses: the block accepts a new access every cycle with no bubbles. Write-then-read of the same address in consecutive cycles returns the new data.
- No X propagation from unselected banks onto dout.

Decomposition:
- Shared package composite_memory_pkg holds:
  - ADDR_WIDTH, DATA_WIDTH, BANK_BITS, OFFSET_WIDTH constants.
  - bank_idx_t and offset_t typedefs.
- One sub-module, memory_bank:
  - Single-port synchronous RAM of BANK_DEPTH x DATA_WIDTH.
  - Ports clk, en, we, addr(offset), din, dout.
  - Registered read when en & ~we.
- Top level composite_memory contains:
  - Decode logic.
  - Four memory_bank instances generated in a loop.
  - Registered bank-select.
  - Output mux into the dout register.

Test Plan:
- Reset: rst=1 for 2 cycles, then idle reads -> dout = 0x00 during and immediately after reset.
- Per-bank write/readback: write 0x0000=A5, 0x4001=5A, 0x8002=3C, 0xC003=7E with one-cycle writes. Then read each address and sample one cycle after the address edge -> A5, 5A, 3C, 7E respectively.
- Bank isolation: write 0x0010=11, 0x4010=22, 0x8010=33, 0xC010=44 -> reads return 11, 22, 33, 44, with no aliasing on the shared offset 0x0010.
- Boundaries: write 0x3FFF=F0, 0x4000=0F, 0xFFFF=AA, 0x0000=55 -> reads return F0, 0F, AA, 55.
- Back-to-back: write 0x1234=C3 in cycle N and read 0x1234 in cycle N+1 -> dout=C3 after edge N+2. During the write cycle dout keeps its prior value.
- Reset mid-operation: assert rst in the same cycle as a write of 0x2000=99, having previously written 0x2000=66. Then read 0x2000 -> 66 (write suppressed), and dout=00 in the cycle after reset.
